// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, queue width and
// the dispenser-compatible coin priority.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_A    = 2'd1,
        COIN_B    = 2'd2,
        COIN_C    = 2'd3
    } coin_e;

    localparam int COIN_VAL_A       = 5;
    localparam int COIN_VAL_B       = 10;
    localparam int COIN_VAL_C       = 20;
    localparam int PEND_W           = 2;
    localparam int DEBOUNCE_DEFAULT = 16;

    // Same A > B > C ordering the dispenser FSM uses.
    function automatic coin_e pick_coin(input logic has_a, input logic has_b, input logic has_c);
        coin_e sel;
        sel = COIN_NONE;
        if (has_a)
            sel = COIN_A;
        else if (has_b)
            sel = COIN_B;
        else if (has_c)
            sel = COIN_C;
        return sel;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse on each accepted rising level.
module coin_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce stage: any agreement with the current level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            level_d <= level;
            if (sync_p1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/coin_input_conditioner.sv
// Vending-machine front end: debounces the coin and switch buttons, queues coin
// presses and feeds them to the dispenser as spaced single-cycle A/B/C pulses.
module coin_input_conditioner
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int GAP_CYCLES      = 2,
    parameter int PEND_MAX        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic coin_a_raw,
    input  logic coin_b_raw,
    input  logic coin_c_raw,
    input  logic sw_raw,
    input  logic water,
    output logic A,
    output logic B,
    output logic C,
    output logic sw,
    output logic coin_overflow
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [PEND_W-1:0] PEND_LIM = PEND_W'(PEND_MAX);

    logic [3:0]        raw_vec;
    logic [3:0]        rise;
    logic [3:0]        level_unused;
    logic [PEND_W-1:0] pend [3];
    logic [GAP_W-1:0]  gap;
    logic [2:0]        issue;
    coin_e             sel;

    // Channel order: 0 = coin A, 1 = coin B, 2 = coin C, 3 = dispense switch.
    assign raw_vec = {sw_raw, coin_c_raw, coin_b_raw, coin_a_raw};

    for (genvar i = 0; i < 4; i++) begin : g_db
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_vec[i]),
            .level(level_unused[i]),
            .rise (rise[i])
        );
    end

    // ---- arbiter stage: choose the next coin while the dispenser is listening
    always_comb begin
        sel = COIN_NONE;
        if (!water && gap == '0)
            sel = pick_coin(pend[0] != '0, pend[1] != '0, pend[2] != '0);
        issue[0] = (sel == COIN_A);
        issue[1] = (sel == COIN_B);
        issue[2] = (sel == COIN_C);
    end

    // A press and an issue of the same coin in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++)
                pend[i] <= '0;
            coin_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                case ({rise[i], issue[i]})
                    2'b10: begin
                        if (pend[i] == PEND_LIM)
                            coin_overflow <= 1'b1;
                        else
                            pend[i] <= pend[i] + 1'b1;
                    end
                    2'b01:   pend[i] <= pend[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // ---- output stage: registered pulses and the inter-coin gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A   <= 1'b0;
            B   <= 1'b0;
            C   <= 1'b0;
            sw  <= 1'b0;
            gap <= '0;
        end else begin
            A  <= issue[0];
            B  <= issue[1];
            C  <= issue[2];
            sw <= rise[3] & water;
            if (|issue)
                gap <= GAP_LOAD;
            else if (gap != '0)
                gap <= gap - 1'b1;
        end
    end

endmodule
